md_stall_ctrl: RTL and testbench
================================

Name: md_stall_ctrl

Overview:
- Pipeline sequencing controller for the five-stage core.
- Owns the multi-cycle mult/div busy sequencer.
- Merges the MD structural hazard with the combinational data-hazard stall and the exception request.
- Drives the enable/clear controls of the PC, D and E pipeline registers; sits beside the hazard unit, between the E-stage MD unit and the pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  single core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dataStall  in  1  combinational data-hazard stall from the hazard unit.
- D_mdUse  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_mdStart  in  1  E-stage instruction starts mult/div this cycle.
- E_mdIsDiv  in  1  qualifies E_mdStart: 1 = div, 0 = mult.
- Req  in  1  exception/interrupt request from CP0 (M stage).
- pc_en  out  1  PC register enable.
- D_en  out  1  D pipeline register enable.
- E_clr  out  1  E pipeline register clear (bubble insert).
- mdBusy  out  1  MD unit busy; registered.
- mdDone  out  1  one-cycle pulse when an operation completes; registered.
- mdStartEff  out  1  start actually accepted; MD unit latches operands on this signal.

Behaviour:
- Reset (reset==0, asynchronous):
  - cnt=0, mdBusy=0, mdDone=0, state=IDLE.
  - Combinational outputs evaluate with mdBusy=0.
- States:
  - IDLE: cnt==0.
  - BUSY: cnt!=0.
  - mdBusy = (state==BUSY), registered from the next-cnt value.
- Start acceptance:
  - mdStartEff = E_mdStart & ~Req & ~mdBusy.
  - E_mdStart while mdBusy is ignored, by design unreachable because the D-stage stall prevents it.
  - Req in the same cycle as E_mdStart cancels the start: the instruction is being flushed.
- Counter:
  - On accepted start in cycle t, cnt loads DIV_CYCLES or MULT_CYCLES at the edge ending t.
  - In BUSY, cnt decrements by 1 every cycle; no saturation is needed.
  - Req during BUSY does not abort; the operation completes (precise HI/LO).
- Done:
  - mdDone goes high for exactly one cycle, the first cycle with cnt==0 after BUSY.
  - For an N-cycle op: mdBusy is high in cycles t+1..t+N; mdDone is high in t+N+1.
- Stall:
  - mdStall = D_mdUse & (mdStartEff | mdBusy).
  - stall = (dataStall | mdStall) & ~Req.
- Outputs:
  - pc_en = ~stall.
  - D_en = ~stall.
  - E_clr = stall.
- Req priority:
  - When Req=1: pc_en=1, D_en=1, E_clr=0.
  - The pipeline registers flush themselves on Req and load the handler PC 0x0000_4180.
- Simultaneous dataStall and mdStall: a single bubble per cycle; no extra state.
- Reset mid-operation: cnt clears immediately and mdDone does not fire.

Optional Feature:
- Macro: STALL_PERF_EN.
- When defined:
  - Adds output stallCnt [31:0] and input perfClr (1).
  - stallCnt increments each cycle stall==1 and wraps at 2^32.
  - Resets to 0 asynchronously on reset; synchronous clear on perfClr, which has priority over increment.
  - mdStallCnt [31:0] counts only cycles where mdStall & ~dataStall & ~Req.
- When undefined: none of these ports or registers exist; all other behaviour is identical.

Decomposition:
- Shared package (mips_defs): MULT_CYCLES and DIV_CYCLES default constants, the handler PC constant 32'h0000_4180, and the md_state_t typedef (IDLE, BUSY).
- One natural sub-module: md_busy_cnt (load/decrement counter producing mdBusy, mdDone).
- Stall merge logic stays in the top module.

Test Plan:
- Mult, no dependent: E_mdStart=1, E_mdIsDiv=0 at t=10 with D_mdUse=0 → mdBusy high t=11..15, mdDone high only at t=16, pc_en constantly 1.
- Div then mflo in D: start at t=20 with D_mdUse=1 held → pc_en=D_en=0 and E_clr=1 for t=20..30, released at t=31, mdDone at t=31.
- Start cancelled by Req: E_mdStart=1 and Req=1 same cycle → mdStartEff=0, mdBusy stays 0, pc_en=1, E_clr=0.
- Req during BUSY: Req pulse at cycle 3 of a div → cnt continues, mdDone still exactly 11 cycles after start; during the Req cycle stall=0.
- Asynchronous reset mid-div: reset low between edges at cycle 4 → mdBusy=0 immediately, no mdDone afterwards, new start accepted right after release.
- STALL_PERF_EN: dataStall high for 7 cycles plus a mult-induced stall of 6 cycles → stallCnt=13, mdStallCnt=6; perfClr → both 0 next cycle.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the core's sequencing logic: default mult/div
// latencies, counter width, exception handler address and the MD
// sequencer state type.
package mips_defs;

  // Default busy durations of the multi-cycle multiply/divide unit
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Counter width; 2**CNT_W must exceed the longest operation
  localparam int CNT_W_DEF = 4;

  // Address the pipeline registers load when an exception is taken
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // MD sequencer state: IDLE while the count is zero, BUSY otherwise
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Busy duration selected by the operation type
  function automatic int md_op_cycles(input logic is_div, input int mult_c, input int div_c);
    if (is_div) begin
      return div_c;
    end else begin
      return mult_c;
    end
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multi-cycle mult/div busy sequencer. An accepted start loads the
// operation length; the count then runs down to zero. busy is high while
// the count is non-zero and done pulses for the single cycle that follows
// the last busy cycle. Operations always run to completion; only reset
// stops them, and a reset-aborted operation never reports done.
module md_busy_cnt
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_eff,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] load_s;
  md_state_t        state_r;
  logic             done_r;

  // Length of the operation being accepted this cycle
  always_comb begin
    load_s = CNT_W'(md_op_cycles(is_div, MULT_CYCLES, DIV_CYCLES));
  end

  // Sequencer: load on start, count down while busy, flag the final step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_eff) begin
            cnt_r   <= load_s;
            state_r <= BUSY;
          end else begin
            cnt_r   <= cnt_r;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end else begin
            state_r <= BUSY;
            done_r  <= 1'b0;
          end
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_r == BUSY);
  assign done = done_r;

endmodule

// File: rtl/md_stall_ctrl.sv
// Pipeline sequencing controller for the five-stage core. Owns the MD busy
// sequencer, merges the MD structural hazard with the data-hazard stall and
// the exception request, and drives the PC/D enables and the E clear.
// An exception request always wins: the pipeline registers flush
// themselves and load the handler PC, so no stall may hold them.
// Optional build macro STALL_PERF_EN adds stall performance counters
// (stallCnt, mdStallCnt) and their synchronous clear input perfClr.
module md_stall_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dataStall,
  input  logic        D_mdUse,
  input  logic        E_mdStart,
  input  logic        E_mdIsDiv,
  input  logic        Req,
`ifdef STALL_PERF_EN
  input  logic        perfClr,
  output logic [31:0] stallCnt,
  output logic [31:0] mdStallCnt,
`endif
  output logic        pc_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        mdBusy,
  output logic        mdDone,
  output logic        mdStartEff
);

  logic md_stall_s;
  logic stall_s;

  // A start raised while busy cannot occur (D stalls the dependent op);
  // a start coinciding with an exception belongs to a flushed instruction.
  assign mdStartEff = E_mdStart & ~Req & ~mdBusy;

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .start_eff(mdStartEff),
    .is_div   (E_mdIsDiv),
    .busy     (mdBusy),
    .done     (mdDone)
  );

  // An MD-using instruction in D waits while the unit is (or is becoming) busy
  assign md_stall_s = D_mdUse & (mdStartEff | mdBusy);
  // Both hazards collapse to one bubble; an exception overrides any stall
  assign stall_s    = (dataStall | md_stall_s) & ~Req;

  assign pc_en = ~stall_s;
  assign D_en  = ~stall_s;
  assign E_clr = stall_s;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] md_stall_cnt_r;

  // Stall cycle counters; clear has priority over counting, both wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r    <= 32'd0;
      md_stall_cnt_r <= 32'd0;
    end else if (perfClr) begin
      stall_cnt_r    <= 32'd0;
      md_stall_cnt_r <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (md_stall_s & ~dataStall & ~Req) begin
        md_stall_cnt_r <= md_stall_cnt_r + 32'd1;
      end else begin
        md_stall_cnt_r <= md_stall_cnt_r;
      end
    end
  end

  assign stallCnt   = stall_cnt_r;
  assign mdStallCnt = md_stall_cnt_r;
`endif

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Bench for md_stall_ctrl: cycle-indexed reference model plus directed
// scenarios with literal expectations.
module tb_md_stall_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dataStall = 1'b0;
  logic        D_mdUse = 1'b0;
  logic        E_mdStart = 1'b0;
  logic        E_mdIsDiv = 1'b0;
  logic        Req = 1'b0;
  logic        pc_en;
  logic        D_en;
  logic        E_clr;
  logic        mdBusy;
  logic        mdDone;
  logic        mdStartEff;
`ifdef STALL_PERF_EN
  logic        perfClr = 1'b0;
  logic [31:0] stallCnt;
  logic [31:0] mdStallCnt;
`endif

  int checks = 0;
  int errors = 0;

  md_stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .dataStall (dataStall),
    .D_mdUse   (D_mdUse),
    .E_mdStart (E_mdStart),
    .E_mdIsDiv (E_mdIsDiv),
    .Req       (Req),
`ifdef STALL_PERF_EN
    .perfClr   (perfClr),
    .stallCnt  (stallCnt),
    .mdStallCnt(mdStallCnt),
`endif
    .pc_en     (pc_en),
    .D_en      (D_en),
    .E_clr     (E_clr),
    .mdBusy    (mdBusy),
    .mdDone    (mdDone),
    .mdStartEff(mdStartEff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // v = {dataStall, D_mdUse, E_mdStart, E_mdIsDiv, Req}, applied just after a rising edge
  task automatic drive(input logic [4:0] v);
    @(posedge clk);
    #1;
    dataStall = v[4];
    D_mdUse   = v[3];
    E_mdStart = v[2];
    E_mdIsDiv = v[1];
    Req       = v[0];
  endtask

  // Reference model: an accepted start in cycle c makes the unit busy for
  // cycles c+1..c+N and done in cycle c+N+1; reset forgets the operation.
  int mc = 0;
  int busy_end = -1;
  int done_at = -1;
  logic [31:0] m_sc = 32'd0;
  logic [31:0] m_msc = 32'd0;

  always @(negedge clk) begin
    logic mb, md, ms, mmd, mst;
    if (!reset) begin
      busy_end = -1;
      done_at  = -1;
      m_sc     = 32'd0;
      m_msc    = 32'd0;
    end
    mb  = (mc <= busy_end);
    md  = (mc == done_at);
    ms  = E_mdStart && !Req && !mb;
    mmd = D_mdUse && (ms || mb);
    mst = (dataStall || mmd) && !Req;
    chk("m_busy", mdBusy, mb);
    chk("m_done", mdDone, md);
    chk("m_starteff", mdStartEff, ms);
    chk("m_pc_en", pc_en, !mst);
    chk("m_d_en", D_en, !mst);
    chk("m_e_clr", E_clr, mst);
`ifdef STALL_PERF_EN
    chk32("m_stallcnt", stallCnt, m_sc);
    chk32("m_mdstallcnt", mdStallCnt, m_msc);
    if (reset) begin
      if (perfClr) begin
        m_sc  = 32'd0;
        m_msc = 32'd0;
      end else begin
        if (mst) m_sc = m_sc + 32'd1;
        if (mmd && !dataStall && !Req) m_msc = m_msc + 32'd1;
      end
    end
`endif
    if (ms && reset) begin
      busy_end = mc + (E_mdIsDiv ? DC : MC);
      done_at  = mc + (E_mdIsDiv ? DC : MC) + 1;
    end
    mc++;
  end

  initial begin
    // Reset state
    drive(5'b00000);
    @(negedge clk);
    chk("rst_busy", mdBusy, 1'b0);
    chk("rst_done", mdDone, 1'b0);
    chk("rst_pc_en", pc_en, 1'b1);
    chk("rst_e_clr", E_clr, 1'b0);
    drive(5'b00000);
    @(posedge clk);
    #1 reset = 1'b1;

    // Mult with no dependent instruction
    drive(5'b00100);
    @(negedge clk);
    chk("mul_starteff", mdStartEff, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      drive(5'b00000);
      @(negedge clk);
      chk("mul_busy", mdBusy, k <= 5);
      chk("mul_done", mdDone, k == 6);
      chk("mul_pc_en", pc_en, 1'b1);
    end

    // Div followed by mflo held in D
    drive(5'b01110);
    @(negedge clk);
    chk("div_pc_en0", pc_en, 1'b0);
    chk("div_d_en0", D_en, 1'b0);
    chk("div_e_clr0", E_clr, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      drive(5'b01000);
      @(negedge clk);
      chk("div_pc_en", pc_en, k >= 11);
      chk("div_e_clr", E_clr, k <= 10);
      chk("div_done", mdDone, k == 11);
    end

    // Start cancelled by an exception request
    drive(5'b11101);
    @(negedge clk);
    chk("cxl_starteff", mdStartEff, 1'b0);
    chk("cxl_pc_en", pc_en, 1'b1);
    chk("cxl_d_en", D_en, 1'b1);
    chk("cxl_e_clr", E_clr, 1'b0);
    drive(5'b00000);
    @(negedge clk);
    chk("cxl_busy", mdBusy, 1'b0);

    // Data hazard alone
    drive(5'b10000);
    @(negedge clk);
    chk("ds_pc_en", pc_en, 1'b0);
    chk("ds_e_clr", E_clr, 1'b1);

    // Req during a div; also a data stall overlapping the MD stall
    drive(5'b00110);
    for (int k = 1; k <= 12; k++) begin
      drive({(k == 5), 1'b1, 1'b0, 1'b0, (k == 2)});
      @(negedge clk);
      chk("rqb_pc_en", pc_en, (k == 2) || (k >= 11));
      chk("rqb_busy", mdBusy, k <= 10);
      chk("rqb_done", mdDone, k == 11);
    end
    drive(5'b00000);

    // Asynchronous reset in the middle of a div
    drive(5'b00110);
    for (int k = 1; k <= 3; k++) drive(5'b00000);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", mdBusy, 1'b0);
    chk("arst_done", mdDone, 1'b0);
    drive(5'b00000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    E_mdStart = 1'b1;
    E_mdIsDiv = 1'b0;
    @(negedge clk);
    chk("arst_restart", mdStartEff, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      drive(5'b00000);
      @(negedge clk);
      chk("arst_done_mul", mdDone, k == 6);
    end

`ifdef STALL_PERF_EN
    // Stall counters: 7 data-stall cycles plus a 6-cycle mult stall
    @(posedge clk);
    #1 perfClr = 1'b1;
    @(posedge clk);
    #1 perfClr = 1'b0;
    for (int k = 0; k < 7; k++) drive(5'b10000);
    drive(5'b00000);
    drive(5'b01100);
    for (int k = 0; k < 6; k++) drive(5'b01000);
    drive(5'b00000);
    drive(5'b00000);
    @(negedge clk);
    chk32("perf_stall", stallCnt, 32'd13);
    chk32("perf_mdstall", mdStallCnt, 32'd6);
    @(posedge clk);
    #1 perfClr = 1'b1;
    @(posedge clk);
    #1 perfClr = 1'b0;
    @(negedge clk);
    chk32("perf_clr_stall", stallCnt, 32'd0);
    chk32("perf_clr_md", mdStallCnt, 32'd0);
`endif

    drive(5'b00000);
    drive(5'b00000);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
